// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: raster counters, DE/HSYNC/VSYNC and frame-stable mode latch for the 800x480 RGB LCD.
// Defining LCD_TIMING_PIPE_ALIGN_EN delays DE/HSYNC/VSYNC by one register to match the renderer's RGB.
module lcd_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 48,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 13,
    parameter int V_SYNC   = 3,
    parameter int V_BP     = 32,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        PixelClk,
    input  logic        RST,
    input  logic [2:0]  mode_req,
    output logic [15:0] PixelCount,
    output logic [15:0] LineCount,
    output logic        LCD_DE,
    output logic        LCD_HSYNC,
    output logic        LCD_VSYNC,
    output logic        frame_start,
    output logic [2:0]  display_mode
);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] H_MAX  = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] V_MAX  = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [15:0] pix_q, pix_d, line_q, line_d;
    logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [2:0]  mode_q, mode_d;

    // Decode from the next counter values so every flag lands with the coordinates it describes.
    always_comb begin
        pix_d  = (pix_q == H_MAX) ? '0 : pix_q + 16'd1;
        line_d = (pix_q != H_MAX) ? line_q : (line_q == V_MAX) ? '0 : line_q + 16'd1;
        de_d   = (pix_d < H_ACT) && (line_d < V_ACT);
        hs_d   = (pix_d >= HS_BEG && pix_d < HS_END) ? HS_POL : ~HS_POL;
        vs_d   = (line_d >= VS_BEG && line_d < VS_END) ? VS_POL : ~VS_POL;
        fs_d   = (pix_d == '0) && (line_d == '0);
        mode_d = (fs_d && mode_req < 3'd2) ? mode_req : mode_q;
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            pix_q  <= H_MAX;
            line_q <= V_MAX;
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            fs_q   <= 1'b0;
            mode_q <= 3'd0;
        end else begin
            pix_q  <= pix_d;
            line_q <= line_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            fs_q   <= fs_d;
            mode_q <= mode_d;
        end
    end

    assign PixelCount   = pix_q;
    assign LineCount    = line_q;
    assign frame_start  = fs_q;
    assign display_mode = mode_q;

`ifdef LCD_TIMING_PIPE_ALIGN_EN
    logic de_p_q, hs_p_q, vs_p_q;

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            de_p_q <= 1'b0;
            hs_p_q <= ~HS_POL;
            vs_p_q <= ~VS_POL;
        end else begin
            de_p_q <= de_q;
            hs_p_q <= hs_q;
            vs_p_q <= vs_q;
        end
    end

    assign LCD_DE    = de_p_q;
    assign LCD_HSYNC = hs_p_q;
    assign LCD_VSYNC = vs_p_q;
`else
    assign LCD_DE    = de_q;
    assign LCD_HSYNC = hs_q;
    assign LCD_VSYNC = vs_q;
`endif
endmodule

// File: tb/tb_lcd_timing_gen.sv
// tb_lcd_timing_gen: checks a full-size and a reduced-geometry instance against a position-from-cycle-count model.
module tb_lcd_timing_gen;
    logic        PixelClk = 1'b0;
    logic        RST = 1'b1;
    logic [2:0]  mode_req = 3'd0;
    logic [15:0] pc_b, lc_b, pc_s, lc_s;
    logic        de_b, hs_b, vs_b, fs_b, de_s, hs_s, vs_s, fs_s;
    logic [2:0]  dm_b, dm_s;

    always #5 PixelClk = ~PixelClk;

    lcd_timing_gen dut_b (
        .PixelClk(PixelClk), .RST(RST), .mode_req(mode_req),
        .PixelCount(pc_b), .LineCount(lc_b), .LCD_DE(de_b), .LCD_HSYNC(hs_b),
        .LCD_VSYNC(vs_b), .frame_start(fs_b), .display_mode(dm_b)
    );

    // Small frame (36 x 19) so whole frames fit the cycle budget; positive sync polarity.
    lcd_timing_gen #(
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(5), .H_BP(7),
        .V_ACTIVE(10), .V_FP(3), .V_SYNC(2), .V_BP(4),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .PixelClk(PixelClk), .RST(RST), .mode_req(mode_req),
        .PixelCount(pc_s), .LineCount(lc_s), .LCD_DE(de_s), .LCD_HSYNC(hs_s),
        .LCD_VSYNC(vs_s), .frame_start(fs_s), .display_mode(dm_s)
    );

    typedef struct packed {
        logic [15:0] px;
        logic [15:0] ln;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } tim_t;

    int   vecs = 0;
    int   errs = 0;
    int   n = -1;
    tim_t eb, es, ob, os;
    tim_t lb = '0;
    tim_t ls = '0;
    logic [2:0] mb, ms;

    // Position is a pure function of edges elapsed since reset release (n < 0 means in reset).
    function automatic tim_t model(int k, int ha, int hf, int hy, int hb,
                                   int va, int vf, int vy, int vb, logic hp, logic vp);
        int   ht = ha + hf + hy + hb;
        int   vt = va + vf + vy + vb;
        int   p, l;
        tim_t t;
        p = (k < 0) ? ht - 1 : k % ht;
        l = (k < 0) ? vt - 1 : (k / ht) % vt;
        t.px = 16'(p);
        t.ln = 16'(l);
        t.de = (p < ha) && (l < va);
        t.hs = (p >= ha + hf && p < ha + hf + hy) ? hp : ~hp;
        t.vs = (l >= va + vf && l < va + vf + vy) ? vp : ~vp;
        t.fs = (k >= 0) && (p == 0) && (l == 0);
        return t;
    endfunction

    task automatic chk(string tag, logic [15:0] a, logic [15:0] e);
        vecs++;
        assert (a === e) else begin
            errs++;
            $error("FAIL %s: got %0d expected %0d (n=%0d)", tag, a, e, n);
        end
    endtask

    task automatic step();
        logic       r;
        logic [2:0] m;
        @(posedge PixelClk);
        r = RST;
        m = mode_req;
        n = r ? -1 : n + 1;
        eb = model(n, 800, 40, 48, 88, 480, 13, 3, 32, 1'b0, 1'b0);
        es = model(n, 20, 4, 5, 7, 10, 3, 2, 4, 1'b1, 1'b1);
        mb = r ? 3'd0 : (eb.fs && m < 3'd2) ? m : mb;
        ms = r ? 3'd0 : (es.fs && m < 3'd2) ? m : ms;
        ob = eb;
        os = es;
`ifdef LCD_TIMING_PIPE_ALIGN_EN
        ob.de = r ? 1'b0 : lb.de;
        ob.hs = r ? 1'b1 : lb.hs;
        ob.vs = r ? 1'b1 : lb.vs;
        os.de = r ? 1'b0 : ls.de;
        os.hs = r ? 1'b0 : ls.hs;
        os.vs = r ? 1'b0 : ls.vs;
`endif
        lb = eb;
        ls = es;
        #1;
        chk("b_pix", pc_b, ob.px);
        chk("b_line", lc_b, ob.ln);
        chk("b_de", 16'(de_b), 16'(ob.de));
        chk("b_hsync", 16'(hs_b), 16'(ob.hs));
        chk("b_vsync", 16'(vs_b), 16'(ob.vs));
        chk("b_fstart", 16'(fs_b), 16'(ob.fs));
        chk("b_mode", 16'(dm_b), 16'(mb));
        chk("s_pix", pc_s, os.px);
        chk("s_line", lc_s, os.ln);
        chk("s_de", 16'(de_s), 16'(os.de));
        chk("s_hsync", 16'(hs_s), 16'(os.hs));
        chk("s_vsync", 16'(vs_s), 16'(os.vs));
        chk("s_fstart", 16'(fs_s), 16'(os.fs));
        chk("s_mode", 16'(dm_s), 16'(ms));
    endtask

    initial begin
        repeat (5) step();
        chk("rst_pix", pc_b, 16'd975);
        chk("rst_line", lc_b, 16'd527);
        RST = 1'b0;
        step();
        chk("rel_pix", pc_b, 16'd0);
        chk("rel_fstart", 16'(fs_b), 16'd1);
        repeat (3 * 976) begin
            mode_req = 3'($urandom_range(0, 7));
            step();
        end
        RST = 1'b1;
        mode_req = 3'd0;
        repeat (2) step();
        RST = 1'b0;
        repeat (200) step();
        mode_req = 3'd1;
        repeat (484) step();
        chk("mode_before_fs", 16'(dm_s), 16'd0);
        step();
        chk("mode_after_fs", 16'(dm_s), 16'd1);
        mode_req = 3'd3;
        repeat (684) step();
        chk("mode_hold_illegal", 16'(dm_s), 16'd1);
        repeat ($urandom_range(50, 600)) step();
        RST = 1'b1;
        repeat (2) step();
        RST = 1'b0;
        step();
        chk("restart_fstart", 16'(fs_s), 16'd1);
        repeat (700) step();
        repeat (1500) begin
            mode_req = 3'($urandom_range(0, 7));
            RST = ($urandom_range(0, 199) == 0);
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
